// File: rtl/cam_scale_down_2x_avg.sv
// 2x2 box-filter downscaler for the 2PPC RGB camera pipe: halves width and height.
// Even rows park horizontal pair sums in a line RAM; odd rows average against them.
module cam_scale_down_2x_avg #(
    parameter int P_DEPTH        = 8,
    parameter int IN_FRAME_WIDTH = 1080,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*P_DEPTH-1:0] in_red,
    input  logic [2*P_DEPTH-1:0] in_green,
    input  logic [2*P_DEPTH-1:0] in_blue,
    input  logic                 in_sof,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*P_DEPTH-1:0] out_red,
    output logic [2*P_DEPTH-1:0] out_green,
    output logic [2*P_DEPTH-1:0] out_blue,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = P_DEPTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IN_FRAME_WIDTH / 2 - 1);

    typedef struct packed {
        logic [SW-1:0] r;
        logic [SW-1:0] g;
        logic [SW-1:0] b;
    } hsum_t;

    typedef struct packed {
        logic [P_DEPTH-1:0] r;
        logic [P_DEPTH-1:0] g;
        logic [P_DEPTH-1:0] b;
    } pix_t;

    function automatic logic [SW-1:0] pair_sum(input logic [2*P_DEPTH-1:0] x);
        return SW'(x[P_DEPTH-1:0]) + SW'(x[2*P_DEPTH-1:P_DEPTH]);
    endfunction

    function automatic logic [P_DEPTH-1:0] avg4(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return P_DEPTH'(((P_DEPTH+2)'(a) + (P_DEPTH+2)'(b) + (P_DEPTH+2)'(2)) >> 2);
    endfunction

    hsum_t                 line_ram [0:2**ADDR_WIDTH-1];
    hsum_t                 ram_hs;
    hsum_t                 p1_hs;
    hsum_t                 in_hs;
    pix_t                  hold;
    pix_t                  avg;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] cur_col;
    logic                  row_odd;
    logic                  cur_odd;
    logic                  p1_valid;
    logic                  p1_second;
    logic                  accept;
    logic                  stall;
    logic                  p1_fire;

    always_comb begin
        stall    = p1_valid & p1_second & out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & in_ready;
        // A start-of-frame beat is re-homed to even row, column 0.
        cur_col  = in_sof ? '0 : col;
        cur_odd  = in_sof ? 1'b0 : row_odd;
        in_hs.r  = pair_sum(in_red);
        in_hs.g  = pair_sum(in_green);
        in_hs.b  = pair_sum(in_blue);
        avg.r    = avg4(ram_hs.r, p1_hs.r);
        avg.g    = avg4(ram_hs.g, p1_hs.g);
        avg.b    = avg4(ram_hs.b, p1_hs.b);
        p1_fire  = p1_valid & ~stall;
    end

    // NOTE: the line RAM and its read register carry no reset; every entry is
    // written on an even row before any odd row reads it, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (rst_n && accept && !cur_odd)
            line_ram[cur_col] <= in_hs;
        if (rst_n && accept && cur_odd)
            ram_hs <= line_ram[cur_col];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row_odd   <= 1'b0;
            hold      <= '0;
            p1_valid  <= 1'b0;
            p1_second <= 1'b0;
            p1_hs     <= '0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                col     <= (cur_col == LAST_COL) ? '0 : cur_col + ADDR_WIDTH'(1);
                row_odd <= (cur_col == LAST_COL) ? ~cur_odd : cur_odd;
            end

            if (accept && cur_odd) begin
                p1_valid  <= 1'b1;
                p1_second <= cur_col[0];
                p1_hs     <= in_hs;
            end else if (!stall) begin
                p1_valid  <= 1'b0;
            end

            if (p1_fire && !p1_second)
                hold <= avg;

            if (p1_fire && p1_second) begin
                out_red   <= {avg.r, hold.r};
                out_green <= {avg.g, hold.g};
                out_blue  <= {avg.b, hold.b};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A new frame abandons any half-built output pair.
            if (accept && in_sof)
                hold <= '0;
        end
    end

endmodule

// File: tb/tb_cam_scale_down_2x_avg.sv
// Directed bench for cam_scale_down_2x_avg on an 8-pixel-wide frame:
// flat fields, ramps, rounding corners, backpressure, mid-row SOF and mid-row reset.
module tb_cam_scale_down_2x_avg;

    localparam int P     = 8;
    localparam int W     = 8;
    localparam int AW    = 3;
    localparam int BEATS = W / 2;
    localparam int LIMIT = 200;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*P-1:0] in_red, in_green, in_blue;
    logic          in_sof, in_valid, in_ready;
    logic [2*P-1:0] out_red, out_green, out_blue;
    logic          out_valid, out_ready;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t rcv_q[$];
    logic [7:0] img_r [4][8];
    logic [7:0] img_g [4][8];
    logic [7:0] img_b [4][8];
    beat_t held;
    bit    stable_ok;
    bit    ready_dropped;

    cam_scale_down_2x_avg #(.P_DEPTH(P), .IN_FRAME_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            rcv_q.push_back('{r: out_red, g: out_green, b: out_blue});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input int row, input int beat, input bit sof);
        int waits = 0;
        in_red   = {img_r[row][2*beat+1], img_r[row][2*beat]};
        in_green = {img_g[row][2*beat+1], img_g[row][2*beat]};
        in_blue  = {img_b[row][2*beat+1], img_b[row][2*beat]};
        in_sof   = sof;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < LIMIT) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= LIMIT) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_rows(input int first, input int last, input bit sof);
        for (int r = first; r <= last; r++)
            for (int b = 0; b < BEATS; b++)
                send_beat(r, b, sof && r == first && b == 0);
    endtask

    function automatic logic [7:0] avg4(input int a, input int b, input int c, input int d);
        int s = a + b + c + d + 2;
        return 8'(s / 4);
    endfunction

    // Output beat o of odd row r covers input pixels 4o..4o+3 of rows r-1 and r.
    function automatic beat_t model_beat(input int r, input int o);
        beat_t bt;
        logic [7:0] lo, hi;
        int k;
        k  = 4 * o;
        lo = avg4(img_r[r-1][k], img_r[r-1][k+1], img_r[r][k], img_r[r][k+1]);
        hi = avg4(img_r[r-1][k+2], img_r[r-1][k+3], img_r[r][k+2], img_r[r][k+3]);
        bt.r = {hi, lo};
        lo = avg4(img_g[r-1][k], img_g[r-1][k+1], img_g[r][k], img_g[r][k+1]);
        hi = avg4(img_g[r-1][k+2], img_g[r-1][k+3], img_g[r][k+2], img_g[r][k+3]);
        bt.g = {hi, lo};
        lo = avg4(img_b[r-1][k], img_b[r-1][k+1], img_b[r][k], img_b[r][k+1]);
        hi = avg4(img_b[r-1][k+2], img_b[r-1][k+3], img_b[r][k+2], img_b[r][k+3]);
        bt.b = {hi, lo};
        return bt;
    endfunction

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int n;
        check($sformatf("%s_count", tag), rcv_q.size(), exp_q.size());
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_red%0d", tag, i), rcv_q[i].r, exp_q[i].r);
            check($sformatf("%s_green%0d", tag, i), rcv_q[i].g, exp_q[i].g);
            check($sformatf("%s_blue%0d", tag, i), rcv_q[i].b, exp_q[i].b);
        end
        rcv_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_red", out_red, 0);
        check("reset_in_ready", in_ready, 1);

        // Flat 0x40 field, four rows.
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < W; x++) begin
                img_r[r][x] = 8'h40; img_g[r][x] = 8'h40; img_b[r][x] = 8'h40;
            end
        @(posedge clk); #1;
        send_rows(0, 3, 1);
        drain();
        repeat (4) exp_q.push_back('{r: 16'h4040, g: 16'h4040, b: 16'h4040});
        compare("flat");

        // Red ramp 0..15 across two rows.
        for (int x = 0; x < W; x++) begin
            img_r[0][x] = 8'(x); img_r[1][x] = 8'(8 + x);
            img_g[0][x] = 0; img_g[1][x] = 0; img_b[0][x] = 0; img_b[1][x] = 0;
        end
        send_rows(0, 1, 1);
        drain();
        check("ramp_beat0", rcv_q[0].r, 16'h0705);
        check("ramp_beat1", rcv_q[1].r, 16'h0B09);
        exp_q.push_back('{r: 16'h0705, g: 16'h0000, b: 16'h0000});
        exp_q.push_back('{r: 16'h0B09, g: 16'h0000, b: 16'h0000});
        compare("ramp");

        // Rounding: red 0,0/0,1 -> 0; green 0,0/1,1 -> 1; blue all 0xFF -> 0xFF.
        for (int x = 0; x < W; x++) begin
            img_r[0][x] = 0; img_r[1][x] = 8'(x % 2);
            img_g[0][x] = 0; img_g[1][x] = 1;
            img_b[0][x] = 8'hFF; img_b[1][x] = 8'hFF;
        end
        send_rows(0, 1, 1);
        drain();
        repeat (2) exp_q.push_back('{r: 16'h0000, g: 16'h0101, b: 16'hFFFF});
        compare("round");

        // Varied image used by the remaining tests.
        for (int r = 0; r < 4; r++)
            for (int x = 0; x < W; x++) begin
                img_r[r][x] = 8'(r * 16 + x * 3);
                img_g[r][x] = 8'(255 - r * 20 - x);
                img_b[r][x] = 8'((r * 37 + x * 11) % 256);
            end

        // Backpressure: hold out_ready low for 10 cycles once the first odd-row beat shows.
        fork
            begin
                send_rows(0, 3, 1);
            end
            begin
                int n = 0;
                while (!out_valid && n < LIMIT) begin
                    @(posedge clk); #1;
                    n++;
                end
                if (n >= LIMIT) check("bp_wait_valid", 0, 1);
                out_ready = 1'b0;
                held = '{r: out_red, g: out_green, b: out_blue};
                stable_ok = 1'b1;
                ready_dropped = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (!out_valid || out_red !== held.r || out_green !== held.g ||
                        out_blue !== held.b)
                        stable_ok = 1'b0;
                    if (!in_ready) ready_dropped = 1'b1;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_data_stable", stable_ok, 1);
        check("bp_in_ready_dropped", ready_dropped, 1);
        exp_q.push_back(model_beat(1, 0));
        exp_q.push_back(model_beat(1, 1));
        exp_q.push_back(model_beat(3, 0));
        exp_q.push_back(model_beat(3, 1));
        compare("bp");

        // SOF on an odd row's third beat restarts the frame.
        send_rows(2, 2, 1);
        send_beat(3, 0, 0);
        send_beat(3, 1, 0);
        send_rows(0, 1, 1);
        drain();
        exp_q.push_back(model_beat(3, 0));
        exp_q.push_back(model_beat(1, 0));
        exp_q.push_back(model_beat(1, 1));
        compare("sof");

        // One-cycle reset in the middle of an odd row, then a frame without SOF.
        send_rows(2, 2, 1);
        send_beat(3, 0, 0);
        send_beat(3, 1, 0);
        send_beat(3, 2, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        rcv_q.delete();
        @(posedge clk); #1;
        send_rows(0, 1, 0);
        drain();
        exp_q.push_back(model_beat(1, 0));
        exp_q.push_back(model_beat(1, 1));
        compare("rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
